// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, simulation constants and width helpers for the button filter
package btn_pkg;

    // Per-channel press-tracking state, kept as plain constants for legacy tools.
    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_IDLE   = 2'd0;
    localparam btn_state_t ST_HOLD   = 2'd1;
    localparam btn_state_t ST_REPEAT = 2'd2;

    // Short windows used when simulating, so a bench runs in a few hundred cycles.
    localparam int DB_CYCLES_SIM = 4;
    localparam int HOLD_SIM      = 8;
    localparam int REPEAT_SIM    = 4;

    // Counter width that never collapses to zero bits for tiny terminal counts.
    function automatic int btn_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one channel: two-flop synchroniser, stability filter and hold/repeat FSM
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DB_W = btn_width(DB_CYCLES);
    localparam int HC_W = btn_width(btn_max(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            s;
    logic [DB_W-1:0] cnt;
    logic            accept;
    logic            accept_press;
    logic            accept_release;
    btn_state_t      state;
    logic [HC_W-1:0] hcnt;

    assign s              = sync_q[1];
    assign accept         = (s != btn_level) && (cnt == DB_LAST);
    assign accept_press   = accept && s;
    assign accept_release = accept && !s;

    // Bring the (optionally inverted) raw input into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw ^ ACTIVE_LOW};
        end
    end

    // Accept a new level only after it has been stable for the whole window; any glitch restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level   <= 1'b0;
            cnt         <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (s == btn_level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                btn_level   <= s;
                cnt         <= '0;
                btn_press   <= s;
                btn_release <= !s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Track how long the button has been held and emit auto-repeat pulses; a release always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hcnt       <= '0;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hcnt <= '0;
                    if (accept_press) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept_release) begin
                        state <= ST_IDLE;
                        hcnt  <= '0;
                    end else if (REPEAT_EN) begin
                        if (hcnt == HOLD_LAST) begin
                            btn_repeat <= 1'b1;
                            state      <= ST_REPEAT;
                            hcnt       <= '0;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (accept_release) begin
                        state <= ST_IDLE;
                        hcnt  <= '0;
                    end else if (hcnt == REP_LAST) begin
                        btn_repeat <= 1'b1;
                        hcnt       <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N independent debounced button channels with press/release/repeat pulses
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int              N_CH          = 4,
    parameter int              DB_CYCLES     = 500000,
    parameter logic [N_CH-1:0] ACTIVE_LOW    = '0,
    parameter bit              REPEAT_EN     = 1'b1,
    parameter int              HOLD_CYCLES   = 50000000,
    parameter int              REPEAT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    // One fully independent filter per input; only the inversion differs between channels.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW[i]),
            .REPEAT_EN     (REPEAT_EN),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - directed vector table plus corner-case sequences for btn_debounce_multi
module tb_btn_debounce_multi;
    import btn_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b1000;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    int n_tests = 0;
    int n_fail  = 0;

    btn_debounce_multi #(
        .N_CH          (4),
        .DB_CYCLES     (DB_CYCLES_SIM),
        .ACTIVE_LOW    (4'b1000),
        .REPEAT_EN     (1'b1),
        .HOLD_CYCLES   (HOLD_SIM),
        .REPEAT_CYCLES (REPEAT_SIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] raw, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel, input logic [3:0] rpt,
                       input int n);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = {btn_level, btn_press, btn_release, btn_repeat};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lvl/prs/rel/rpt=%h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ch0(input logic lvl, input logic prs, input logic rel, input logic rpt);
        return {3'b000, lvl, 3'b000, prs, 3'b000, rel, 3'b000, rpt};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset, clean press/release on ch0
        add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        add(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
        add(0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        // bouncing ch1, then settled high
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
        add(0, 4'b1010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        // active-low ch3 and active-high ch2 pressed together
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b0100, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 1);
        add(0, 4'b0100, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            btn_raw = vecs[i].raw;
            step();
            check($sformatf("vec%0d", i), {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rpt});
        end

        // auto-repeat, then release accepted exactly on a repeat boundary
        btn_raw = 4'b1001;
        for (int k = 1; k <= 5; k++) begin step(); check("ar_wait", ch0(0, 0, 0, 0)); end
        step(); check("ar_press", ch0(1, 1, 0, 0));
        for (int k = 1; k <= 40; k++) begin
            if (k == 27) btn_raw = 4'b1000;
            step();
            check($sformatf("ar_hold_%0d", k),
                  ch0(k < 32, 1'b0, k == 32, (k >= 8) && (k < 32) && ((k - 8) % 4 == 0)));
        end

        // fresh press after release: first repeat again 8 cycles later, so hcnt was cleared
        btn_raw = 4'b1001;
        for (int k = 1; k <= 5; k++) begin step(); check("re_wait", ch0(0, 0, 0, 0)); end
        step(); check("re_press", ch0(1, 1, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) btn_raw = 4'b1000;
            step();
            check($sformatf("re_hold_%0d", k), ch0(k < 15, 1'b0, k == 15, (k == 8) || (k == 12)));
        end

        // reset while a press is pending (filter counter at 2)
        btn_raw = 4'b1001;
        for (int k = 1; k <= 4; k++) begin step(); check("rp_wait", ch0(0, 0, 0, 0)); end
        reset = 1'b1;
        step(); check("rp_reset", ch0(0, 0, 0, 0));
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rp_after_%0d", k), ch0(k == 6, k == 6, 0, 0));
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("rp_hold_%0d", k), ch0(1, 0, 0, k == 8));
        end

        // reset while in auto-repeat with the button still held
        reset = 1'b1;
        step(); check("rr_reset", ch0(0, 0, 0, 0));
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rr_after_%0d", k), ch0(k == 6, k == 6, 0, 0));
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("rr_hold_%0d", k), ch0(1, 0, 0, k == 8));
        end
        btn_raw = 4'b1000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("rr_rel_%0d", k), ch0(k < 6, 0, k == 6, k == 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
